// File: rtl/game_state_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : game_state_controller_if
// Brief    : Game-control bundle between the sequencer and the rest of the game.
// Revision : 1.0
// ============================================================================
interface game_state_controller_if #(
    parameter int SCORE_W = 10
);
    logic               game_en;
    logic               start_n;
    logic               pause;
    logic               collision;
    logic               obstacle_passed;
    logic [1:0]         state;
    logic               run_en;
    logic               obstacle_respawn;
    logic               hit_flash;
    logic [1:0]         lives;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] high_score;

    // master is the sequencer; slave is the surrounding game fabric
    modport master (
        input  game_en, start_n, pause, collision, obstacle_passed,
        output state, run_en, obstacle_respawn, hit_flash, lives, score, high_score
    );

    modport slave (
        output game_en, start_n, pause, collision, obstacle_passed,
        input  state, run_en, obstacle_respawn, hit_flash, lives, score, high_score
    );
endinterface
`default_nettype wire

// File: rtl/game_state_controller.sv
`default_nettype none
// ============================================================================
// Module   : game_state_controller
// Brief    : IDLE/PLAY/HIT/OVER sequencer owning lives, score and high score.
// Revision : 1.0
// ============================================================================
module game_state_controller #(
    parameter logic [1:0]   LIVES_INIT = 2'd3,
    parameter logic [7:0]   HIT_TICKS  = 8'd60,
    parameter int           SCORE_W    = 10,
    parameter logic [SCORE_W-1:0] SCORE_MAX = 10'd999
) (
    input  wire logic            clk,
    input  wire logic            rst,
    game_state_controller_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_HIT  = 2'b10,
        ST_OVER = 2'b11
    } state_t;

    localparam logic [7:0] c_HIT_LOAD = (HIT_TICKS == 8'd0) ? 8'd1 : HIT_TICKS;

    logic               r_sync1;
    logic               r_sync2;
    logic               r_sync3;
    logic               r_start_pulse;

    state_t             r_state;
    logic [1:0]         r_lives;
    logic [SCORE_W-1:0] r_score;
    logic [SCORE_W-1:0] r_high;
    logic [7:0]         r_timer;
    logic               r_respawn;

    state_t             w_state_nx;
    logic [1:0]         w_lives_nx;
    logic [SCORE_W-1:0] w_score_nx;
    logic [SCORE_W-1:0] w_high_nx;
    logic [7:0]         w_timer_nx;
    logic               w_respawn_nx;
    logic               w_hit_q;
    logic               w_pass_q;

    // Button synchroniser; falling edge is taken between the 2nd and 3rd stage
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1       <= 1'b1;
            r_sync2       <= 1'b1;
            r_sync3       <= 1'b1;
            r_start_pulse <= 1'b0;
        end else begin
            r_sync1       <= bus.start_n;
            r_sync2       <= r_sync1;
            r_sync3       <= r_sync2;
            r_start_pulse <= r_sync3 & ~r_sync2;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_lives   <= LIVES_INIT;
            r_score   <= '0;
            r_high    <= '0;
            r_timer   <= 8'd0;
            r_respawn <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_lives   <= w_lives_nx;
            r_score   <= w_score_nx;
            r_high    <= w_high_nx;
            r_timer   <= w_timer_nx;
            r_respawn <= w_respawn_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_lives_nx   = r_lives;
        w_score_nx   = r_score;
        w_high_nx    = r_high;
        w_timer_nx   = r_timer;
        w_respawn_nx = 1'b0;

        // A qualified collision suppresses any same-cycle score increment
        w_hit_q  = bus.game_en & ~bus.pause & bus.collision;
        w_pass_q = bus.obstacle_passed & ~bus.pause & ~w_hit_q;

        case (r_state)
            ST_IDLE, ST_OVER: begin
                if (r_start_pulse) begin
                    w_state_nx   = ST_PLAY;
                    w_lives_nx   = LIVES_INIT;
                    w_score_nx   = '0;
                    w_respawn_nx = 1'b1;
                end
            end
            ST_PLAY: begin
                if (w_hit_q) begin
                    w_respawn_nx = 1'b1;
                    w_lives_nx   = r_lives - 2'd1;
                    if (r_lives <= 2'd1) begin
                        w_state_nx = ST_OVER;
                        w_lives_nx = 2'd0;
                        w_high_nx  = (r_score > r_high) ? r_score : r_high;
                    end else begin
                        w_state_nx = ST_HIT;
                        w_timer_nx = c_HIT_LOAD;
                    end
                end else if (w_pass_q && (r_score < SCORE_MAX)) begin
                    w_score_nx = r_score + SCORE_W'(1);
                end
            end
            ST_HIT: begin
                if (bus.game_en) begin
                    if (r_timer <= 8'd1) begin
                        w_state_nx = ST_PLAY;
                        w_timer_nx = 8'd0;
                    end else begin
                        w_timer_nx = r_timer - 8'd1;
                    end
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    assign bus.state            = r_state;
    assign bus.run_en           = bus.game_en & (r_state == ST_PLAY) & ~bus.pause;
    assign bus.obstacle_respawn = r_respawn;
    assign bus.hit_flash        = (r_state == ST_HIT);
    assign bus.lives            = r_lives;
    assign bus.score            = r_score;
    assign bus.high_score       = r_high;

endmodule
`default_nettype wire

// File: tb/tb_game_state_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_state_controller
// Brief    : Directed scoreboard bench for game_state_controller.
// Revision : 1.0
// ============================================================================
module tb_game_state_controller;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    game_state_controller_if #(.SCORE_W(10)) bus ();

    game_state_controller #(
        .LIVES_INIT (2'd3),
        .HIT_TICKS  (8'd60),
        .SCORE_W    (10),
        .SCORE_MAX  (10'd999)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   m_score;
    int   m_lives;
    int   m_high;

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0d expected=<entry>", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cyc(2);
        m_lives = 3; m_score = 0; m_high = 0;
        push_exp("rst_state", 0);
        push_exp("rst_lives", 3);
        push_exp("rst_score", 0);
        push_exp("rst_high", 0);
        push_exp("rst_run_en", 0);
        bus.game_en = 1'b1;
        #1;
        pop_chk(32'(bus.state));
        pop_chk(32'(bus.lives));
        pop_chk(32'(bus.score));
        pop_chk(32'(bus.high_score));
        pop_chk(32'(bus.run_en));
        bus.game_en = 1'b0;
        rst = 1'b1;
        cyc(1);
    endtask

    task automatic press_start(input int hold);
        int pulses = 0;
        int resp   = 0;
        bus.start_n = 1'b0;
        m_lives = 3; m_score = 0;
        push_exp("start_pulses", 1);
        push_exp("start_respawns", 1);
        push_exp("start_state", 1);
        push_exp("start_lives", 3);
        push_exp("start_score", 0);
        for (int i = 0; i < hold; i++) begin
            cyc(1);
            if (dut.r_start_pulse) pulses++;
            if (bus.obstacle_respawn) resp++;
        end
        bus.start_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            if (dut.r_start_pulse) pulses++;
            if (bus.obstacle_respawn) resp++;
        end
        pop_chk(32'(pulses));
        pop_chk(32'(resp));
        pop_chk(32'(bus.state));
        pop_chk(32'(bus.lives));
        pop_chk(32'(bus.score));
    endtask

    task automatic pass_n(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            bus.obstacle_passed = 1'b1;
            if (!bus.pause && m_score < 999) m_score++;
            cyc(1);
            bus.obstacle_passed = 1'b0;
        end
        push_exp(tag, 32'(m_score));
        pop_chk(32'(bus.score));
    endtask

    task automatic hit_tick(input logic with_pass);
        bus.collision       = 1'b1;
        bus.game_en         = 1'b1;
        bus.obstacle_passed = with_pass;
        m_lives--;
        if (m_lives == 0) m_high = (m_score > m_high) ? m_score : m_high;
        push_exp("hit_lives", 32'(m_lives));
        push_exp("hit_state", (m_lives == 0) ? 3 : 2);
        push_exp("hit_respawn", 1);
        push_exp("hit_score", 32'(m_score));
        push_exp("hit_flash", (m_lives == 0) ? 0 : 1);
        cyc(1);
        bus.collision       = 1'b0;
        bus.game_en         = 1'b0;
        bus.obstacle_passed = 1'b0;
        pop_chk(32'(bus.lives));
        pop_chk(32'(bus.state));
        pop_chk(32'(bus.obstacle_respawn));
        pop_chk(32'(bus.score));
        pop_chk(32'(bus.hit_flash));
        push_exp("respawn_clear", 0);
        cyc(1);
        pop_chk(32'(bus.obstacle_respawn));
        if (m_lives == 0) begin
            push_exp("over_high", 32'(m_high));
            pop_chk(32'(bus.high_score));
        end
    endtask

    // Collision is held through HIT to show it is ignored, then dropped before exit
    task automatic hit_wait();
        for (int t = 1; t <= 60; t++) begin
            bus.collision = (t < 60);
            bus.game_en   = 1'b1;
            cyc(1);
            bus.game_en   = 1'b0;
            if (t == 59) begin
                push_exp("hit_hold_state", 2);
                push_exp("hit_hold_lives", 32'(m_lives));
                pop_chk(32'(bus.state));
                pop_chk(32'(bus.lives));
            end
        end
        bus.collision = 1'b0;
        push_exp("hit_exit_state", 1);
        pop_chk(32'(bus.state));
    endtask

    initial begin
        rst                 = 1'b0;
        bus.game_en         = 1'b0;
        bus.start_n         = 1'b1;
        bus.pause           = 1'b0;
        bus.collision       = 1'b0;
        bus.obstacle_passed = 1'b0;
        cyc(1);

        do_reset();

        // Long hold yields a single start pulse
        press_start(100);
        bus.game_en = 1'b1;
        push_exp("run_en_on", 1);
        #1 pop_chk(32'(bus.run_en));
        bus.game_en = 1'b0;
        push_exp("run_en_off", 0);
        #1 pop_chk(32'(bus.run_en));
        cyc(1);

        pass_n("score_5", 5);
        bus.pause   = 1'b1;
        bus.game_en = 1'b1;
        push_exp("pause_run_en", 0);
        #1 pop_chk(32'(bus.run_en));
        bus.game_en = 1'b0;
        pass_n("pause_score", 3);
        bus.pause = 1'b0;
        pass_n("score_998", 993);
        pass_n("score_sat", 3);

        do_reset();
        press_start(5);
        pass_n("score_7", 7);
        hit_tick(1'b0);
        hit_wait();
        hit_tick(1'b0);
        hit_wait();
        hit_tick(1'b0);

        press_start(5);
        push_exp("restart_high", 7);
        pop_chk(32'(bus.high_score));
        pass_n("score_4", 4);
        hit_tick(1'b1);
        hit_wait();
        hit_tick(1'b0);
        hit_wait();
        hit_tick(1'b0);

        press_start(5);
        hit_tick(1'b0);
        rst = 1'b0;
        cyc(1);
        rst = 1'b1;
        push_exp("midhit_state", 0);
        push_exp("midhit_lives", 3);
        push_exp("midhit_score", 0);
        push_exp("midhit_high", 0);
        push_exp("midhit_flash", 0);
        pop_chk(32'(bus.state));
        pop_chk(32'(bus.lives));
        pop_chk(32'(bus.score));
        pop_chk(32'(bus.high_score));
        pop_chk(32'(bus.hit_flash));
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
